// File: rtl/etcpu_mem_sys.sv
// Boot loader and memory subsystem for etcpu: 1-cycle fetch/read latency, ld_rdy high only in LOAD, no stalls on the memory ports.
// Optional ETCPU_MEM_SYS_OOB_CHK_EN: drop out-of-range main-memory accesses and raise a sticky flag; otherwise addresses wrap.
module etcpu_mem_sys #(
  parameter int DAT_W          = 32,
  parameter int INST_MEM_DEPTH = 256,
  parameter int MAIN_MEM_DEPTH = 32,
  parameter int RST_HOLD_CYC   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_start,
  input  logic               ld_vld,
  output logic               ld_rdy,
  input  logic [DAT_W-1:0]   ld_dat,
  input  logic               ld_last,
  output logic               ld_done,
  output logic               ld_err,
  output logic               cpu_rst_n,
  input  logic [31:0]        inst_mem_addr,
  output logic [DAT_W-1:0]   inst_mem_dat_out,
  input  logic               main_mem_cs,
  input  logic               main_mem_wen,
  input  logic [DAT_W/8-1:0] main_mem_be,
  input  logic [31:0]        main_mem_addr,
  input  logic [DAT_W-1:0]   main_mem_dat_in,
  output logic [DAT_W-1:0]   main_mem_dat_out,
  output logic               main_mem_oob_err
);

  localparam int BE_W  = DAT_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IAW   = $clog2(INST_MEM_DEPTH);
  localparam int MAW   = $clog2(MAIN_MEM_DEPTH);
  localparam int CNT_W = $clog2(RST_HOLD_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [IAW:0]           ptr_q;
  logic [CNT_W-1:0]       hold_q;
  logic                   ld_err_q;
  logic                   run_q;
  logic [DAT_W-1:0]       fetch_q;
  logic [DAT_W-1:0]       imem_q [INST_MEM_DEPTH];
  logic [BE_W-1:0][7:0]   mm_q [MAIN_MEM_DEPTH];
  logic [DAT_W-1:0]       rd_q;
  logic                   oob_q;

  logic                   ld_hs;
  logic                   enter_load;
  logic [IAW-1:0]         fetch_idx;
  logic [MAW-1:0]         m_idx;
  logic                   m_oob;
  logic                   unused_addr;

  assign ld_rdy     = (state_q == S_LOAD);
  assign ld_hs      = ld_vld && ld_rdy;
  assign enter_load = (state_q != S_LOAD) && (state_d == S_LOAD);
  assign fetch_idx  = inst_mem_addr[OFF_W+IAW-1:OFF_W];
  assign m_idx      = main_mem_addr[OFF_W+MAW-1:OFF_W];
  assign unused_addr = ^{inst_mem_addr, main_mem_addr};

`ifdef ETCPU_MEM_SYS_OOB_CHK_EN
  assign m_oob = |main_mem_addr[31:OFF_W+MAW];
`else
  assign m_oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ld_start) state_d = S_LOAD;
      S_LOAD:    if (ld_hs && ld_last) state_d = S_RELEASE;
      S_RELEASE: if (hold_q == CNT_W'(RST_HOLD_CYC - 1)) state_d = S_RUN;
      S_RUN:     if (ld_start) state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pointer carries one extra bit so it can saturate at INST_MEM_DEPTH and flag overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      ld_err_q <= 1'b0;
      run_q    <= 1'b0;
      fetch_q  <= '0;
      for (int i = 0; i < INST_MEM_DEPTH; i++) imem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == S_RUN);
      fetch_q <= (state_q == S_RUN) ? imem_q[fetch_idx] : '0;
      if (enter_load) begin
        ptr_q  <= '0;
        hold_q <= '0;
      end else begin
        if (state_q == S_RELEASE) hold_q <= hold_q + CNT_W'(1);
        if (ld_hs) begin
          if (ptr_q[IAW]) begin
            ld_err_q <= 1'b1;
          end else begin
            imem_q[ptr_q[IAW-1:0]] <= ld_dat;
            ptr_q <= ptr_q + (IAW+1)'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      oob_q <= 1'b0;
      for (int i = 0; i < MAIN_MEM_DEPTH; i++) mm_q[i] <= '0;
    end else if (main_mem_cs) begin
      if (m_oob) begin
        oob_q <= 1'b1;
        if (!main_mem_wen) rd_q <= '0;
      end else if (main_mem_wen) begin
        for (int b = 0; b < BE_W; b++)
          if (main_mem_be[b]) mm_q[m_idx][b] <= main_mem_dat_in[8*b +: 8];
      end else begin
        rd_q <= mm_q[m_idx];
      end
    end
  end

  assign ld_done          = run_q;
  assign cpu_rst_n        = run_q;
  assign ld_err           = ld_err_q;
  assign inst_mem_dat_out = fetch_q;
  assign main_mem_dat_out = rd_q;
  assign main_mem_oob_err = oob_q;

endmodule
